// File: rtl/door_lock_ctrl.sv
// rtl/door_lock_ctrl.sv - door-lock controller: fingerprint/PIN access, failure counting, timed lockout
module door_lock_ctrl #(
  parameter logic [15:0] PIN           = 16'h1234,
  parameter int          MAX_FAIL      = 3,
  parameter int          OPEN_CYCLES   = 50,
  parameter int          LOCK_CYCLES   = 100,
  parameter int          ENTRY_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic       fp_valid,
  input  logic [3:0] num,
  input  logic       key_valid,
  output logic       open,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt,
  output logic       err
);

  localparam int TMAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMAX    = (TMAX_OL > ENTRY_TIMEOUT) ? TMAX_OL : ENTRY_TIMEOUT;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAIL);
  localparam logic [3:0]    KEY_ENTER  = 4'hA;
  localparam logic [3:0]    KEY_CLEAR  = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   entry_buf, buf_n;
  logic [2:0]    dcnt_n;
  logic          overflow, ovf_n;
  logic [1:0]    fcnt_n, fail_next;
  logic          err_n;
  logic          is_digit, pin_ok;
  logic          do_open, do_fail, do_clear, tmr_clr;

  assign is_digit  = (num <= 4'd9);
  assign pin_ok    = (digit_cnt == 3'd4) && !overflow && (entry_buf == PIN);
  assign fail_next = fail_cnt + 2'd1;

  // Registered state, entry buffer, counters and outputs; outputs follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      entry_buf <= '0;
      digit_cnt <= '0;
      overflow  <= 1'b0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      open      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      entry_buf <= buf_n;
      digit_cnt <= dcnt_n;
      overflow  <= ovf_n;
      fail_cnt  <= fcnt_n;
      err       <= err_n;
      open      <= (state_n == S_OPEN);
      alarm     <= (state_n == S_LOCKOUT);
    end
  end

  // Next-state decision: fingerprint beats keys, grant/fail actions applied after the state case.
  always_comb begin
    state_n  = state;
    buf_n    = entry_buf;
    dcnt_n   = digit_cnt;
    ovf_n    = overflow;
    fcnt_n   = fail_cnt;
    err_n    = 1'b0;
    do_open  = 1'b0;
    do_fail  = 1'b0;
    do_clear = 1'b0;
    tmr_clr  = 1'b0;

    case (state)
      S_IDLE: begin
        if (fp_valid) begin
          do_open = !s;
          do_fail = s;
        end else if (key_valid && is_digit) begin
          state_n = S_ENTRY;
          buf_n   = {12'h000, num};
          dcnt_n  = 3'd1;
          ovf_n   = 1'b0;
        end
      end
      S_ENTRY: begin
        if (fp_valid) begin
          do_open = !s;
          do_fail = s;
        end else if (key_valid) begin
          tmr_clr = 1'b1;
          if (is_digit) begin
            if (digit_cnt < 3'd4) begin
              buf_n  = {entry_buf[11:0], num};
              dcnt_n = digit_cnt + 3'd1;
            end else begin
              ovf_n = 1'b1;
            end
          end else if (num == KEY_ENTER) begin
            do_open = pin_ok;
            do_fail = !pin_ok;
          end else if (num == KEY_CLEAR) begin
            state_n  = S_IDLE;
            do_clear = 1'b1;
          end
        end else if (timer == ENTRY_LAST) begin
          state_n  = S_IDLE;
          do_clear = 1'b1;
        end
      end
      S_OPEN: begin
        if (timer == OPEN_LAST) state_n = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_n = S_IDLE;
          fcnt_n  = 2'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (do_open) begin
      state_n  = S_OPEN;
      fcnt_n   = 2'd0;
      do_clear = 1'b1;
    end
    if (do_fail) begin
      err_n    = 1'b1;
      fcnt_n   = fail_next;
      do_clear = 1'b1;
      state_n  = (fail_next == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
    end
    if (do_clear) begin
      buf_n  = '0;
      dcnt_n = 3'd0;
      ovf_n  = 1'b0;
    end

    if (state_n != state || state_n == S_IDLE || tmr_clr) timer_n = '0;
    else                                                  timer_n = timer + TIMER_ONE;
  end

endmodule
